instr_fetch_unit: RTL

//  Producer side of the program-counter path. Generates the next fetch address, issues
//  req/ack reads to instruction memory, and presents {instr, pc} to decode through a
//  1-entry output register plus a 1-entry skid buffer. Supports stall back-pressure
//  and a branch redirect that discards any in-flight fetch.

---
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC generation, req/ack instruction-memory reads, and a
// registered {instr, pc} output stage backed by a one-entry skid buffer.
`timescale 1ns/1ps

module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_next;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                if_valid_d;
  logic [INSTR_W-1:0]  if_instr_d;
  logic [ADDR_W-1:0]   if_pc_d;
  logic [INSTR_W-1:0]  skid_instr;
  logic [ADDR_W-1:0]   skid_pc;
  logic                skid_load;
  logic                consumed;
  logic                slot_free;

  // A request is outstanding in FETCH and DRAIN; HOLD parks the pipe while the skid is full.
  assign mem_req   = (state_q == FETCH) || (state_q == DRAIN);
  assign consumed  = if_valid & ~stall;
  assign slot_free = ~if_valid | ~stall;
  assign pc_next   = pc_q + ADDR_W'(PC_STEP);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr;
    if_valid_d = consumed ? 1'b0 : if_valid;
    if_instr_d = if_instr;
    if_pc_d    = if_pc;
    skid_load  = 1'b0;

    if (branch_valid) begin
      // Flush: the output slot and skid are dropped; the HOLD exit below also empties the skid.
      pc_d       = branch_target;
      if_valid_d = 1'b0;
      unique case (state_q)
        FETCH: begin
          if (mem_ack) mem_addr_d = branch_target;
          else         state_d    = DRAIN;
        end
        HOLD, IDLE: begin
          mem_addr_d = branch_target;
          state_d    = FETCH;
        end
        default: ;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          mem_addr_d = pc_q;
          state_d    = FETCH;
        end
        FETCH: begin
          if (mem_ack) begin
            pc_d = pc_next;
            if (slot_free) begin
              if_valid_d = 1'b1;
              if_instr_d = mem_rdata;
              if_pc_d    = mem_addr;
              mem_addr_d = pc_next;
            end else begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            if_valid_d = 1'b1;
            if_instr_d = skid_instr;
            if_pc_d    = skid_pc;
            mem_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          // The late response belongs to the abandoned path and is discarded.
          if (mem_ack) begin
            mem_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      mem_addr <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mem_addr <= mem_addr_d;
      if_valid <= if_valid_d;
      if_instr <= if_instr_d;
      if_pc    <= if_pc_d;
    end
  end

  // NOTE: skid payload is not reset; it is only read in HOLD, which is entered solely after a load.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_instr <= mem_rdata;
      skid_pc    <= mem_addr;
    end
  end

endmodule
